// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB requester: FSM states, register map, defaults.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Byte offsets of the UART registers reachable over APB
  localparam logic [7:0] REG_ENABLE  = 8'h00;
  localparam logic [7:0] REG_CONTROL = 8'h04;
  localparam logic [7:0] REG_STATUS  = 8'h08;
  localparam logic [7:0] REG_DATA    = 8'h0C;

  // Number of ACCESS cycles tolerated before a transfer is aborted
  localparam int DEFAULT_TIMEOUT = 16;

  // APB registers are word wide, so only word-aligned byte addresses are legal
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/uart_apb_master.sv
// Single-outstanding APB requester: turns a cmd/rsp handshake into APB
// SETUP/ACCESS cycles, with misaligned-address rejection and an ACCESS timeout.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  state_e              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [7:0]          wait_q, wait_d;

  // Next-state and next-output logic for the transfer FSM and wait counter
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wait_d      = wait_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (!is_word_aligned(cmd_addr[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_wdata;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wait_d    = 8'd1;
      end

      ACCESS: begin
        if (PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          wait_d      = 8'd0;
        end else if (wait_q == 8'(TIMEOUT)) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          wait_d      = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_q      <= wait_d;
    end
  end

  // Ready is held low while reset is applied even though the state reads IDLE
  assign cmd_ready = (state_q == IDLE) && !PRESET;

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Self-checking bench for uart_apb_master: vector table plus scoreboard of
// expected responses, and hand-written reset and back-to-back sequences.
module tb_uart_apb_master;
  import uart_apb_pkg::*;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] prdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expAccess;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  vec_t vecs[8];
  vec_t noVec;
  int   assertCount = 0;
  int   failCount   = 0;

  uart_apb_master #(
    .ADDR_W (5),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  // Free-running 10-unit clock
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Last-resort guard so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: event did not occur, required within budget", name);
  endtask

  // Offer a command and wait for acceptance; returns on the negedge after it
  task automatic sendCmd(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expRdata, input logic expErr);
    rsp_t r;
    bit   ok = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        ok = 1;
        break;
      end
      @(negedge PCLK);
    end
    if (!ok) reportFail("cmdAccept");
    @(posedge PCLK);
    r.rdata = expRdata;
    r.err   = expErr;
    sb.push_back(r);
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  // Hold the response for a while, then handshake and compare with the scoreboard
  task automatic consumeRsp(input int hold);
    rsp_t exp;
    rsp_t got;
    for (int i = 0; i < hold; i++) begin
      checkOutput("holdValid", rsp_valid, 1);
      checkOutput("holdCmdReady", cmd_ready, 0);
      if (sb.size() > 0) begin
        checkOutput("holdRdata", rsp_rdata, sb[0].rdata);
        checkOutput("holdErr", rsp_err, sb[0].err);
      end
      @(negedge PCLK);
    end
    got.rdata = rsp_rdata;
    got.err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge PCLK);
    if (sb.size() == 0) begin
      reportFail("scoreboardEmpty");
    end else begin
      exp = sb.pop_front();
      checkOutput("rspRdata", got.rdata, exp.rdata);
      checkOutput("rspErr", got.err, exp.err);
    end
    @(negedge PCLK);
    rsp_ready = 1'b0;
    checkOutput("rspDropped", rsp_valid, 0);
  endtask

  // Run one vector: issue it, act as the completer, check bus and response
  task automatic applyStimulus(input vec_t v, input int hold, input bit offerNext, input vec_t nextV);
    int cyc       = 1;
    int accessCnt = 0;
    int setupCnt  = 0;
    bit got       = 0;
    sendCmd(v.wr, v.addr, v.wdata, v.expRdata, v.expErr);
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin
        got = 1;
        break;
      end
      if (PSEL && !PENABLE) begin
        setupCnt++;
        PREADY = 1'b1;
        PRDATA = 32'hBAD0_BAD0;
      end else if (PSEL && PENABLE) begin
        accessCnt++;
        checkOutput("busAddr", PADDR, v.addr);
        checkOutput("busWrite", PWRITE, v.wr);
        checkOutput("busWdata", PWDATA, v.wdata);
        PREADY = (accessCnt > v.delay);
        PRDATA = PREADY ? v.prdata : ~v.prdata;
      end else begin
        PREADY = 1'b0;
      end
      @(negedge PCLK);
      cyc++;
    end
    PREADY = 1'b0;
    if (!got) begin
      reportFail("rspValid");
    end else begin
      checkOutput("setupCycles", setupCnt, (v.expAccess == 0) ? 0 : 1);
      checkOutput("accessCycles", accessCnt, v.expAccess);
      checkOutput("latency", cyc, (v.expAccess == 0) ? 1 : 2 + v.expAccess);
      checkOutput("pselAfter", PSEL, 0);
      if (offerNext) begin
        cmd_valid = 1'b1;
        cmd_write = nextV.wr;
        cmd_addr  = nextV.addr;
        cmd_wdata = nextV.wdata;
      end
      consumeRsp(hold);
      if (offerNext) checkOutput("nextCmdReady", cmd_ready, 1);
    end
  endtask

  initial begin
    vec_t b2bA;
    vec_t b2bB;
    bit   reached;

    vecs[0] = '{1'b1, 5'(REG_ENABLE), 32'h3, 0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1};
    vecs[1] = '{1'b0, 5'(REG_STATUS), 32'h0, 3, 32'h1C, 32'h1C, 1'b0, 4};
    vecs[2] = '{1'b0, 5'(REG_DATA), 32'h0, 255, 32'h55, 32'h0, 1'b1, 16};
    vecs[3] = '{1'b1, 5'h05, 32'h77, 0, 32'h0, 32'h0, 1'b1, 0};
    vecs[4] = '{1'b1, 5'(REG_DATA), 32'hA5A5_0F0F, 15, 32'h1234, 32'h0, 1'b0, 16};
    vecs[5] = '{1'b0, 5'(REG_CONTROL), 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2};
    vecs[6] = '{1'b0, 5'h10, 32'h0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1};
    vecs[7] = '{1'b0, 5'h1E, 32'h0, 0, 32'hFFFF_0000, 32'h0, 1'b1, 0};
    noVec   = vecs[0];

    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PRDATA    = '0;

    #1;
    checkOutput("resetCmdReady", cmd_ready, 0);
    checkOutput("resetPsel", PSEL, 0);
    checkOutput("resetRspValid", rsp_valid, 0);
    checkOutput("resetPaddr", PADDR, 0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    checkOutput("releaseCmdReady", cmd_ready, 1);
    @(negedge PCLK);

    $display("[TB] running vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], (i % 3), 1'b0, noVec);
    end

    $display("[TB] reset during ACCESS");
    sendCmd(1'b0, 5'(REG_STATUS), 32'h0, 32'h0, 1'b0);
    reached = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        reached = 1;
        break;
      end
    end
    if (!reached) reportFail("reachAccess");
    @(negedge PCLK);
    #2;
    PRESET = 1'b1;
    #1;
    checkOutput("midResetPsel", PSEL, 0);
    checkOutput("midResetPenable", PENABLE, 0);
    checkOutput("midResetPwrite", PWRITE, 0);
    checkOutput("midResetPaddr", PADDR, 0);
    checkOutput("midResetPwdata", PWDATA, 0);
    checkOutput("midResetRspValid", rsp_valid, 0);
    checkOutput("midResetRdata", rsp_rdata, 0);
    checkOutput("midResetCmdReady", cmd_ready, 0);
    sb.delete();
    @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    checkOutput("midReleaseCmdReady", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      checkOutput("noRspAfterReset", rsp_valid, 0);
      checkOutput("noBusAfterReset", PSEL, 0);
    end
    applyStimulus(vecs[6], 0, 1'b0, noVec);

    $display("[TB] back-to-back writes with held response");
    b2bA = '{1'b1, 5'(REG_CONTROL), 32'h11, 0, 32'h0, 32'h0, 1'b0, 1};
    b2bB = '{1'b1, 5'(REG_DATA), 32'h22, 2, 32'h0, 32'h0, 1'b0, 3};
    applyStimulus(b2bA, 5, 1'b1, b2bB);
    applyStimulus(b2bB, 1, 1'b0, noVec);

    checkOutput("scoreboardDrained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
